regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, register width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, register count (power of two, >=4); AW = clog2(NREGS) is derived, not overridable.
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port ready, output, 1, high once the post-reset clear sequence has completed.
REQ-007 The block SHALL have port rd_addr, input, NUM_RD*AW, packed read addresses, port k at bits [k*AW +: AW].
REQ-008 The block SHALL have port rd_data, output, NUM_RD*XLEN, packed combinational read data.
REQ-009 The block SHALL have port rd_busy, output, NUM_RD, per-port pending-write (scoreboard) flag.
REQ-010 The block SHALL have ports wr0_en/wr1_en (input, 1), wr0_addr/wr1_addr (input, AW) and wr0_data/wr1_data (input, XLEN), two write-back ports.
REQ-011 The block SHALL have ports iss_en (input, 1) and iss_addr (input, AW), marking a destination register as pending.

Function
REQ-012 Register 0 SHALL always read 0 and SHALL never be busy; writes and issues to address 0 are ignored.
REQ-013 FSM states SHALL be CLEAR and RUN; CLEAR writes 0 to register clr_idx each cycle, incrementing clr_idx, and moves to RUN after writing index NREGS-1.
REQ-014 ready SHALL be 0 in CLEAR and 1 in RUN; it rises on the NREGS-th rising edge after reset_n deasserts.
REQ-015 While ready=0, wr*_en and iss_en SHALL be ignored, rd_data SHALL read all zeros and rd_busy all zeros.
REQ-016 In RUN, wrN_en=1 SHALL update register wrN_addr at the rising edge; when both ports target the same nonzero address, wr1 SHALL win.
REQ-017 A write-back on either port SHALL clear busy[wrN_addr] at the same edge.
REQ-018 iss_en=1 SHALL set busy[iss_addr] at the edge; if a write-back targets the same address in the same cycle, busy SHALL end up set (issue wins).
REQ-019 rd_data[k] SHALL equal the stored value of rd_addr[k], and rd_busy[k] SHALL equal busy[rd_addr[k]], both combinational, subject to REQ-012 and REQ-025.
REQ-020 All address arithmetic SHALL be AW bits wide; clr_idx SHALL not wrap past NREGS-1 in RUN.

Reset
REQ-021 Asserting reset_n low SHALL immediately force state=CLEAR, clr_idx=0, ready=0 and all busy bits to 0, including mid-CLEAR or mid-operation.
REQ-022 Register array contents SHALL not be reset asynchronously; zeroing occurs only via the CLEAR sequence.
REQ-023 Reset reasserted during CLEAR SHALL restart the sequence from index 0.

Configuration
REQ-024 Macro REGFILE_MP_BYPASS_EN SHALL select write-to-read forwarding.
REQ-025 With REGFILE_MP_BYPASS_EN defined and in RUN, a read whose address matches an active write-back SHALL return that cycle's write data (wr1 over wr0) with rd_busy[k]=0 unless iss_en targets the same address; address 0 still reads 0.
REQ-026 Without REGFILE_MP_BYPASS_EN, reads SHALL return the stored value, with written data visible from the cycle after the write edge.

Verification
REQ-027 Release reset with NREGS=32 -> ready=0 for 31 edges, ready=1 after the 32nd; every register reads 0.
REQ-028 Write wr0 x5=0xDEADBEEF and wr1 x5=0x12345678 in one cycle -> x5 reads 0x12345678 next cycle; write x0=0xFFFFFFFF -> x0 reads 0.
REQ-029 Issue x7, then write-back x7=0xA5 two cycles later -> rd_busy=1 for those cycles, 0 afterwards; issue and write-back x7 in the same cycle -> busy stays 1.
REQ-030 With bypass on, read x9 while writing x9=0x55 -> rd_data=0x55 same cycle; with bypass off -> old value, then 0x55 next cycle.
REQ-031 Assert reset_n mid-CLEAR at index 10 and after busy bits are set in RUN -> ready drops immediately, busy clears, and the sequence restarts taking 32 edges.
REQ-032 XLEN=64, NREGS=16, NUM_RD=3 -> all three ports read independent addresses correctly; ready after 16 edges.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register file bus: read ports, two write-back ports, issue port and ready.
interface regfile_mp_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic                     ready;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*XLEN-1:0]   rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [AW-1:0]            wr0_addr;
  logic [XLEN-1:0]          wr0_data;
  logic                     wr1_en;
  logic [AW-1:0]            wr1_addr;
  logic [XLEN-1:0]          wr1_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;

  modport master (
    input  ready, rd_data, rd_busy,
    output rd_addr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, iss_en, iss_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  rd_addr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, iss_en, iss_addr
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard and post-reset clear.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write-back data to reads.
module regfile_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NUM_RD = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_mp_if.slave  bus
);
  localparam int unsigned AW   = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_n;
  logic [AW-1:0]       clr_idx, clr_idx_n;
  logic                ready_q, ready_n;
  logic [NREGS-1:0]    busy, busy_n;
  logic                clr_we, run;
  logic [XLEN-1:0]     mem [NREGS];
  logic [AW-1:0]       ra;
  logic [NUM_RD*XLEN-1:0] rd_data_c;
  logic [NUM_RD-1:0]   rd_busy_c;

  // State, clear index, ready and scoreboard registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready_q <= 1'b0;
      busy    <= '0;
    end else begin
      state   <= state_n;
      clr_idx <= clr_idx_n;
      ready_q <= ready_n;
      busy    <= busy_n;
    end
  end

  // Next state: leave CLEAR once the last index has been zeroed
  always_comb begin
    state_n = state;
    case (state)
      CLEAR:   if (clr_idx == LAST) state_n = RUN;
      RUN:     state_n = RUN;
      default: state_n = CLEAR;
    endcase
  end

  // Outputs: clear strobe, clear index advance, ready and scoreboard update
  always_comb begin
    clr_we    = (state == CLEAR);
    run       = (state == RUN);
    ready_n   = (state_n == RUN);
    clr_idx_n = clr_idx;
    busy_n    = busy;
    if (clr_we && clr_idx != LAST) clr_idx_n = clr_idx + AW'(1);
    if (run) begin
      if (bus.wr0_en) busy_n[bus.wr0_addr] = 1'b0;
      if (bus.wr1_en) busy_n[bus.wr1_addr] = 1'b0;
      // a new issue outranks a retiring write-back to the same register
      if (bus.iss_en) busy_n[bus.iss_addr] = 1'b1;
    end
    busy_n[0] = 1'b0;
  end

  // Storage: zeroed by the CLEAR walk only, wr1 lands last so it wins
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (run) begin
      if (bus.wr0_en && bus.wr0_addr != '0) mem[bus.wr0_addr] <= bus.wr0_data;
      if (bus.wr1_en && bus.wr1_addr != '0) mem[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  // Combinational read ports with x0 and not-ready masking
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra        = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      ra = bus.rd_addr[k*AW +: AW];
      if (ready_q && ra != '0) begin
        rd_data_c[k*XLEN +: XLEN] = mem[ra];
        rd_busy_c[k]              = busy[ra];
`ifdef REGFILE_MP_BYPASS_EN
        if (run && bus.wr1_en && bus.wr1_addr == ra) begin
          rd_data_c[k*XLEN +: XLEN] = bus.wr1_data;
          rd_busy_c[k]              = bus.iss_en && (bus.iss_addr == ra);
        end else if (run && bus.wr0_en && bus.wr0_addr == ra) begin
          rd_data_c[k*XLEN +: XLEN] = bus.wr0_data;
          rd_busy_c[k]              = bus.iss_en && (bus.iss_addr == ra);
        end
`endif
      end
    end
  end

  assign bus.ready   = ready_q;
  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build plus a 64-bit/16-reg/3-port instance.
module tb_regfile_mp;
  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2)) bus ();
  regfile_mp_if #(.XLEN(64), .NREGS(16), .NUM_RD(3)) bus64 ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  regfile_mp #(.XLEN(64), .NREGS(16), .NUM_RD(3)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .bus(bus64)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr0_en = 1'b0;   bus.wr0_addr = '0;   bus.wr0_data = '0;
    bus.wr1_en = 1'b0;   bus.wr1_addr = '0;   bus.wr1_data = '0;
    bus.iss_en = 1'b0;   bus.iss_addr = '0;
    bus64.wr0_en = 1'b0; bus64.wr0_addr = '0; bus64.wr0_data = '0;
    bus64.wr1_en = 1'b0; bus64.wr1_addr = '0; bus64.wr1_data = '0;
    bus64.iss_en = 1'b0; bus64.iss_addr = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    idle();
    bus.rd_addr   = {5'd1, 5'd31};
    bus64.rd_addr = '0;
    // inputs during CLEAR must be ignored
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd31; bus.wr0_data = 32'hCAFE_F00D;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd1;
    #2;
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_ready64", 64'(bus64.ready), 64'd0);
    #10 reset_n = 1'b1;

    // clear sequence: 32 edges for the default instance, 16 for the wide one
    for (int e = 1; e <= 32; e++) begin
      tick();
      chk("clr_ready", 64'(bus.ready), 64'(e >= 32));
      chk("clr_ready64", 64'(bus64.ready), 64'(e >= 16));
      if (e == 20) begin
        chk("clr_rd_data", 64'(bus.rd_data), 64'd0);
        chk("clr_rd_busy", 64'(bus.rd_busy), 64'd0);
      end
    end
    idle();

    // every register reads zero after clear
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr = {5'(31 - i), 5'(i)};
      #1;
      chk("zero", 64'(bus.rd_data), 64'd0);
      chk("zero_busy", 64'(bus.rd_busy), 64'd0);
    end

    // same-address dual write: wr1 wins
    bus.rd_addr = {5'd0, 5'd5};
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hDEAD_BEEF;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd5; bus.wr1_data = 32'h1234_5678;
    #1;
    chk("x5_pre", 64'(bus.rd_data[31:0]), BYP ? 64'h1234_5678 : 64'd0);
    tick();
    idle();
    chk("x5_post", 64'(bus.rd_data[31:0]), 64'h1234_5678);

    // write to x0 ignored; distinct-address dual write
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'hFFFF_FFFF;
    tick();
    idle();
    chk("x0_read", 64'(bus.rd_data[63:32]), 64'd0);
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h0000_0011;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd4; bus.wr1_data = 32'h0000_0022;
    tick();
    idle();
    bus.rd_addr = {5'd4, 5'd3};
    #1;
    chk("x3_read", 64'(bus.rd_data[31:0]), 64'h11);
    chk("x4_read", 64'(bus.rd_data[63:32]), 64'h22);

    // scoreboard: issue x7, write back two cycles later
    bus.rd_addr = {5'd7, 5'd5};
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    #1;
    chk("busy_pre_iss", 64'(bus.rd_busy), 64'd0);
    tick();
    idle();
    chk("busy_c1", 64'(bus.rd_busy), 64'b10);
    tick();
    chk("busy_c2", 64'(bus.rd_busy), 64'b10);
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'hA5;
    #1;
    chk("busy_wb_pre", 64'(bus.rd_busy[1]), BYP ? 64'd0 : 64'd1);
    tick();
    idle();
    chk("busy_wb_post", 64'(bus.rd_busy), 64'd0);
    chk("x7_data", 64'(bus.rd_data[63:32]), 64'hA5);

    // issue and write-back same cycle: issue wins
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'hB6;
    #1;
    chk("iss_wb_pre", 64'(bus.rd_busy[1]), BYP ? 64'd1 : 64'd0);
    tick();
    idle();
    chk("iss_wb_busy", 64'(bus.rd_busy[1]), 64'd1);
    chk("iss_wb_data", 64'(bus.rd_data[63:32]), 64'hB6);

    // issue to x0 is ignored
    bus.rd_addr = {5'd7, 5'd0};
    bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
    tick();
    idle();
    chk("x0_busy", 64'(bus.rd_busy[0]), 64'd0);

    // forwarding vs registered visibility on x9
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'h33;
    tick();
    idle();
    bus.rd_addr = {5'd7, 5'd9};
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'h55;
    #1;
    chk("x9_same", 64'(bus.rd_data[31:0]), BYP ? 64'h55 : 64'h33);
    tick();
    idle();
    chk("x9_next", 64'(bus.rd_data[31:0]), 64'h55);

    // wide instance: three independent read ports
    bus64.wr0_en = 1'b1; bus64.wr0_addr = 4'd1;  bus64.wr0_data = 64'h0123_4567_89AB_CDEF;
    bus64.wr1_en = 1'b1; bus64.wr1_addr = 4'd15; bus64.wr1_data = 64'hFEDC_BA98_7654_3210;
    tick();
    bus64.wr0_en = 1'b1; bus64.wr0_addr = 4'd2;  bus64.wr0_data = 64'h5A5A_A5A5_0F0F_F0F0;
    bus64.wr1_en = 1'b1; bus64.wr1_addr = 4'd0;  bus64.wr1_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle();
    bus64.rd_addr = {4'd2, 4'd15, 4'd1};
    #1;
    chk("w64_p0", bus64.rd_data[63:0],    64'h0123_4567_89AB_CDEF);
    chk("w64_p1", bus64.rd_data[127:64],  64'hFEDC_BA98_7654_3210);
    chk("w64_p2", bus64.rd_data[191:128], 64'h5A5A_A5A5_0F0F_F0F0);
    bus64.rd_addr = {4'd0, 4'd1, 4'd2};
    #1;
    chk("w64_q0", bus64.rd_data[63:0],    64'h5A5A_A5A5_0F0F_F0F0);
    chk("w64_q1", bus64.rd_data[127:64],  64'h0123_4567_89AB_CDEF);
    chk("w64_q2", bus64.rd_data[191:128], 64'd0);
    bus64.rd_addr = {4'd2, 4'd15, 4'd1};
    bus64.iss_en = 1'b1; bus64.iss_addr = 4'd15;
    tick();
    idle();
    chk("w64_busy", 64'(bus64.rd_busy), 64'b010);

    // reset mid-operation with busy bits set
    bus.iss_en = 1'b1; bus.iss_addr = 5'd8;
    tick();
    idle();
    bus.rd_addr = {5'd8, 5'd7};
    #1;
    chk("busy_before_rst", 64'(bus.rd_busy), 64'b11);
    reset_n = 1'b0;
    #1;
    chk("rst_run_ready", 64'(bus.ready), 64'd0);
    chk("rst_run_ready64", 64'(bus64.ready), 64'd0);
    chk("rst_run_busy", 64'(bus.rd_busy), 64'd0);
    #1 reset_n = 1'b1;

    // reset again at clear index 10; sequence restarts and takes 32 edges
    for (int e = 1; e <= 10; e++) tick();
    chk("mid_clr_ready", 64'(bus.ready), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_clr_rst", 64'(bus.ready), 64'd0);
    #1 reset_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e == 31) chk("restart_31", 64'(bus.ready), 64'd0);
      if (e == 32) chk("restart_32", 64'(bus.ready), 64'd1);
    end
    bus.rd_addr = {5'd8, 5'd7};
    #1;
    chk("post_rst_busy", 64'(bus.rd_busy), 64'd0);
    chk("post_rst_x7", 64'(bus.rd_data[31:0]), 64'd0);
    bus.rd_addr = {5'd9, 5'd5};
    #1;
    chk("post_rst_x5", 64'(bus.rd_data[31:0]), 64'd0);
    chk("post_rst_x9", 64'(bus.rd_data[63:32]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
